// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared FSM states, tick default and width helper
// for the status-LED blink arbiter and its prescaler.
package led_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ON,
    OFF,
    GAP,
    FIN
  } state_t;

  // 50 ms tick from the 48 MHz internal oscillator
  localparam int TICK_48MHZ = 2400000;

  // bits needed to hold 0..n-1 (at least one)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_seq_arbiter_if.sv
// led_seq_arbiter_if: request/ack/done bundle plus LED status.
// master drives req/count_in; slave returns ack/done/busy/owner/led.
interface led_seq_arbiter_if
  import led_seq_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
);

  localparam int OW = cnt_w(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] count_in;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [OW-1:0]         owner;
  logic                  led;

  modport master (
    output req, count_in,
    input  ack, done, busy, owner, led
  );

  modport slave (
    input  req, count_in,
    output ack, done, busy, owner, led
  );

endinterface

// File: rtl/led_seq_arbiter_tick_prescaler.sv
// tick_prescaler: divides clk by TICK_CYCLES, one-cycle tick on
// the terminal count; clr restarts the count synchronously.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_48MHZ
)(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/led_seq_arbiter.sv
// led_seq_arbiter: fixed-priority owner of the status LED; plays
// N blinks then a dark gap. Ports: clk, reset, bus (slave modport).
// Optional idle heartbeat: define LED_SEQ_HEARTBEAT_EN.
module led_seq_arbiter
  import led_seq_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int CNT_W       = 4,
  parameter int TICK_CYCLES = TICK_48MHZ,
  parameter int ON_TICKS    = 4,
  parameter int OFF_TICKS   = 4,
  parameter int GAP_TICKS   = 20,
  parameter int HB_TICKS    = 10
)(
  input  logic            clk,
  input  logic            reset,
  led_seq_arbiter_if.slave bus
);

  localparam int OW = cnt_w(NREQ);
  localparam int M1 =
    (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int M2 =
    (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
  localparam int PH_MAX = (M1 > M2) ? M1 : M2;
  localparam int PH_W = cnt_w(PH_MAX);

  state_t state, nxt;

  logic             tick;
  logic             clr;
  logic [PH_W-1:0]  ph;
  logic [PH_W-1:0]  ph_lim;
  logic             ph_done;
  logic             ph_run;
  logic [CNT_W-1:0] rem;

  logic             gnt_any;
  logic [OW-1:0]    gnt_idx;
  logic [CNT_W-1:0] gnt_cnt;
  logic             grant;

  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             led_q, led_d;

  // lowest index wins: scan high to low so low overwrites
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = OW'(i);
      end
    end
  end

  assign gnt_cnt =
    bus.count_in[gnt_idx*CNT_W +: CNT_W];
  assign grant = (state == IDLE) && gnt_any;

  // every state change restarts the phase timing
  assign clr = (nxt != state);

  tick_prescaler #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  always_comb begin
    ph_lim = '0;
    unique case (state)
      IDLE:    ph_lim = PH_W'(HB_TICKS - 1);
      ON:      ph_lim = PH_W'(ON_TICKS - 1);
      OFF:     ph_lim = PH_W'(OFF_TICKS - 1);
      GAP:     ph_lim = PH_W'(GAP_TICKS - 1);
      default: ph_lim = '0;
    endcase
  end

`ifdef LED_SEQ_HEARTBEAT_EN
  assign ph_run = 1'b1;
`else
  assign ph_run = (state != IDLE);
`endif

  assign ph_done = tick && ph_run && (ph == ph_lim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ph <= '0;
    else if (clr || ph_done)
      ph <= '0;
    else if (tick && ph_run)
      ph <= ph + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rem <= '0;
    else if (grant)
      rem <= gnt_cnt;
    else if ((state == ON) && ph_done)
      rem <= rem - 1'b1;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  // next state; FIN holds until its done pulse is out, so a
  // zero-count grant spends ack and done in separate cycles
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (gnt_any)
          nxt = (gnt_cnt != '0) ? ON : FIN;
      ON:
        if (ph_done)
          nxt = OFF;
      OFF:
        if (ph_done)
          nxt = (rem != '0) ? ON : GAP;
      GAP:
        if (ph_done)
          nxt = FIN;
      FIN:
        if (done_q != '0)
          nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  // output decode, registered below
  always_comb begin
    ack_d   = '0;
    done_d  = '0;
    busy_d  = (nxt != IDLE);
    owner_d = owner_q;
    led_d   = (nxt == ON);
    if (grant) begin
      ack_d[gnt_idx] = 1'b1;
      owner_d        = gnt_idx;
    end
    if ((nxt == FIN) && (state != IDLE))
      done_d[owner_q] = 1'b1;
`ifdef LED_SEQ_HEARTBEAT_EN
    if ((nxt == IDLE) && (state == IDLE))
      led_d = ph_done ? ~led_q : led_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      led_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      led_q   <= led_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;
  assign bus.led   = led_q;

endmodule

// File: tb/tb_led_seq_arbiter.sv
// tb_led_seq_arbiter: directed steps with an ack/done event
// scoreboard plus per-cycle LED/busy/owner pattern checks.
module tb_led_seq_arbiter;

  localparam int NREQ = 4;
  localparam int CNT_W = 4;
  localparam int TCK = 4;
  localparam int ONT = 2;
  localparam int OFFT = 1;
  localparam int GAPT = 3;
  localparam int HBT = 2;
  localparam int ONC = ONT * TCK;
  localparam int OFFC = OFFT * TCK;
  localparam int GAPC = GAPT * TCK;
  localparam int HBC = HBT * TCK;

  typedef struct {
    bit is_done;
    int idx;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];

  led_seq_arbiter_if #(
    .NREQ(NREQ),
    .CNT_W(CNT_W)
  ) bus ();

  led_seq_arbiter #(
    .NREQ(NREQ),
    .CNT_W(CNT_W),
    .TICK_CYCLES(TCK),
    .ON_TICKS(ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT),
    .HB_TICKS(HBT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int dur_of(input int n);
    return (n == 0) ? 1 : n * (ONC + OFFC) + GAPC;
  endfunction

  function automatic logic led_exp(input int n,
                                   input int t);
    if (n == 0) return 1'b0;
    if (t < n * (ONC + OFFC))
      return ((t % (ONC + OFFC)) < ONC);
    return 1'b0;
  endfunction

  task automatic exp_push(input bit d, input int idx,
                          input int c);
    ev_t e;
    e.is_done = d;
    e.idx = idx;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic set_cnt(input int idx, input int v);
    bus.count_in[idx*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic take_ev(input bit d,
                         input logic [NREQ-1:0] vec);
    ev_t e;
    logic [NREQ-1:0] one;
    if (exp_q.size() == 0) begin
      chk(d ? "spurious_done" : "spurious_ack",
          32'(vec), 32'h0);
      return;
    end
    e = exp_q.pop_front();
    one = '0;
    one[e.idx] = 1'b1;
    chk("ev_kind", 32'(d), 32'(e.is_done));
    chk(d ? "done_vec" : "ack_vec", 32'(vec), 32'(one));
    chk(d ? "done_cyc" : "ack_cyc", cyc, e.cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ack != '0) take_ev(1'b0, bus.ack);
    if (bus.done != '0) take_ev(1'b1, bus.done);
    if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      chk("overdue_ev", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic pattern_chk(input int own, input int n);
    int dur;
    dur = dur_of(n);
    for (int t = 0; t <= dur; t++) begin
      chk("led", 32'(bus.led), 32'(led_exp(n, t)));
      chk("busy", 32'(bus.busy), 32'h1);
      chk("owner", 32'(bus.owner), own);
      if (t < dur) step();
    end
    step();
    chk("busy_end", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int a;
    logic hb;
    checks = 0;
    errors = 0;
    cyc = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.count_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_led", 32'(bus.led), 32'h0);
    step();

    // single requester, two blinks
    set_cnt(0, 2);
    bus.req = 4'b0001;
    exp_push(1'b0, 0, cyc + 1);
    exp_push(1'b1, 0, cyc + 1 + dur_of(2));
    step();
    bus.req = '0;
    pattern_chk(0, 2);

    // simultaneous 0 and 2: 0 first, 2 two cycles after done
    set_cnt(0, 1);
    set_cnt(2, 1);
    bus.req = 4'b0101;
    a = cyc + 1;
    exp_push(1'b0, 0, a);
    exp_push(1'b1, 0, a + dur_of(1));
    exp_push(1'b0, 2, a + dur_of(1) + 2);
    exp_push(1'b1, 2, a + 2 * dur_of(1) + 2);
    step();
    bus.req[0] = 1'b0;
    pattern_chk(0, 1);
    step();
    bus.req[2] = 1'b0;
    pattern_chk(2, 1);

    // zero count: ack then done, no LED
    set_cnt(1, 0);
    bus.req = 4'b0010;
    exp_push(1'b0, 1, cyc + 1);
    exp_push(1'b1, 1, cyc + 2);
    step();
    bus.req = '0;
    pattern_chk(1, 0);

    // reset five cycles into ON aborts with no done
    set_cnt(0, 2);
    bus.req = 4'b0001;
    exp_push(1'b0, 0, cyc + 1);
    step();
    bus.req = '0;
    repeat (5) step();
    chk("pre_rst_led", 32'(bus.led), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_led", 32'(bus.led), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_ack", 32'(bus.ack), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (45) step();
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    // req dropped right after ack still plays fully
    set_cnt(3, 1);
    bus.req = 4'b1000;
    exp_push(1'b0, 3, cyc + 1);
    exp_push(1'b1, 3, cyc + 1 + dur_of(1));
    step();
    bus.req = '0;
    pattern_chk(3, 1);

    // idle LED: heartbeat toggles every HBC cycles, else dark
    for (int t = 0; t < 100; t++) begin
`ifdef LED_SEQ_HEARTBEAT_EN
      hb = 1'(((t / HBC) % 2));
`else
      hb = 1'b0;
`endif
      chk("idle_led", 32'(bus.led), 32'(hb));
      step();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_arbiter.md
# led_seq_arbiter

Shares the board's single status LED between up to NREQ requesters and plays a blink-count pattern for the winning requester, clocked from the 48 MHz internal oscillator clock. Fixed priority arbitration: index 0 highest. Each granted request blinks the LED N times, then holds a dark gap so consecutive patterns are distinguishable. With the heartbeat feature compiled in, the LED shows a slow idle toggle when no pattern is playing.

## Interface
- NREQ, 4, number of requesters (2..8)
- CNT_W, 4, width of per-requester blink count
- TICK_CYCLES, 2400000, clk cycles per tick (50 ms at 48 MHz)
- ON_TICKS, 4, ticks LED is lit per blink
- OFF_TICKS, 4, ticks LED is dark between blinks
- GAP_TICKS, 20, dark ticks after last blink before done
- HB_TICKS, 10, ticks per heartbeat half-period (used only with heartbeat)

- clk  in  1  system clock, 48 MHz
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  request lines, level, held until ack
- count_in  in  NREQ*CNT_W  blink count per requester, slice i at [i*CNT_W +: CNT_W]
- ack  out  NREQ  one-cycle pulse: request i accepted, count latched
- done  out  NREQ  one-cycle pulse: pattern for i finished
- busy  out  1  high from ack through done cycle inclusive
- owner  out  $clog2(NREQ)  index of current owner, valid while busy
- led  out  1  LED drive, 1 = lit

## Operation
- States: IDLE, ON, OFF, GAP, FIN.
- IDLE: if any req, pick lowest index i; next edge: ack[i]=1, latch count_in slice into remaining, owner=i, busy=1. If count nonzero -> ON, led=1, tick counter cleared. If count zero -> FIN (no LED activity).
- ON: after ON_TICKS ticks -> OFF, led=0, remaining decremented.
- OFF: after OFF_TICKS ticks -> ON (led=1) if remaining nonzero, else GAP.
- GAP: after GAP_TICKS ticks -> FIN.
- FIN: one cycle, done[owner]=1, busy stays 1; next edge -> IDLE, busy=0.
- req dropping after ack is ignored; the latched pattern always completes. req still high after done is treated as a new request.
- Requests arriving while busy wait; no queuing beyond level req.
- Tick counter: 0..TICK_CYCLES-1, tick on terminal value; cleared on every state entry, so each phase lasts exactly ticks*TICK_CYCLES cycles.
- Reset mid-operation: abort immediately, no done, all outputs to reset values.

## Timing
- Reset values: ack=0, done=0, busy=0, owner=0, led=0, state IDLE, counters 0.
- All outputs registered; req sampled in IDLE, ack one cycle after req seen.
- Blink phase durations: ON = ON_TICKS*TICK_CYCLES cycles, OFF = OFF_TICKS*TICK_CYCLES, GAP = GAP_TICKS*TICK_CYCLES.
- Count N>0: ack edge to done = N*(ON+OFF)+GAP cycles; done to next possible ack = 2 cycles (FIN->IDLE, IDLE->ack).
- Count 0: done asserted the cycle after ack.
- Simultaneous req: lowest index wins; losers see ack no earlier than 2 cycles after winner's done.

## Configuration
- LED_SEQ_HEARTBEAT_EN defined: in IDLE, led toggles every HB_TICKS ticks; heartbeat counter and led cleared to 0 on each entry to IDLE; grant overrides heartbeat immediately.
- Not defined: led held 0 in IDLE; no heartbeat counter logic.

## Structure
- Package led_seq_pkg: state enum (IDLE, ON, OFF, GAP, FIN), default tick constant for 48 MHz, helper width function for tick counter.
- Sub-module tick_prescaler: TICK_CYCLES divider with synchronous clear and tick pulse output; instantiated once.
- Arbitration priority encoder and FSM stay in top module.

## Test plan
Bench params: TICK_CYCLES=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, HB_TICKS=2.
- req[0]=1, count 2 -> ack[0] next cycle; led 1 for 8, 0 for 4, 1 for 8, 0 for 4+12; done[0] 36 cycles after ack.
- req[0] and req[2] same cycle -> ack[0] first; ack[2] exactly 2 cycles after done[0]; owner 0 then 2.
- req[1], count 0 -> ack[1] then done[1] next cycle; led never rises; busy high 2 cycles.
- reset asserted 5 cycles into ON -> led, busy, ack, done immediately 0; no done pulse after release.
- req[3] dropped right after ack, count 1 -> full pattern plays, done[3] at 24 cycles after ack.
- With LED_SEQ_HEARTBEAT_EN, idle -> led toggles every 8 cycles; without, led stays 0 for 100 cycles.
